mem_arbiter: RTL and testbench

- Sequences and shares the single-port 8-bit system RAM between two requesters: requester 0 (CPU) and requester 1 (DMA/IO).
- Generates the RAM address, write enable, output enable (MEMBUS) and input enable (BUSMEM), and owns the bidirectional RAM data bus.
- Runs one access at a time, with round-robin arbitration and a fixed multi-cycle access sequence.
- Sits between the requesters and the RAM in the top level.

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/mem_arbiter_rr_arb2.sv | 35 +++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory arbiter: FSM state encoding and requester ids.
package mem_arb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin grant logic. When both requesters are high the pointer
// decides; after every grant the pointer moves to the requester that lost.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic grant_en,
  output logic grant_id
);

  logic ptr;

  // Pick the winner: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    grant_id = REQ_CPU;
    if (req0 && req1) begin
      grant_id = ptr;
    end else if (req1) begin
      grant_id = REQ_DMA;
    end
  end

  // Pointer moves to the other requester whenever a grant is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= REQ_CPU;
    end else if (grant_en) begin
      ptr <= ~grant_id;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port RAM between requester 0 (CPU) and requester 1 (DMA/IO).
// One access at a time: IDLE -> SETUP -> ACCESS (1 + WAIT_STATES) -> DONE.
// Build option: MEM_ARBITER_FIXED_PRIO_EN replaces round-robin with fixed
// priority (requester 0 wins ties) and drops the pointer register.
//
// state  | meaning
// IDLE   | waiting for a request; arbitration and latching happen here
// SETUP  | address on the bus, all strobes low
// ACCESS | read: output enable high; write: write enable + data driven
// DONE   | ack to the owner, strobes low, bus released
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wr0,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  output logic                  mem_membus,
  output logic                  mem_busmem,
  output logic                  busy,
  output logic                  owner
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  logic [1:0]            state_q;
  logic [3:0]            wait_cnt;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  req_any;
  logic                  grant_id;
  logic                  access_last;
  logic                  write_phase;

  assign req_any = req0 | req1;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
  assign grant_id = req0 ? REQ_CPU : REQ_DMA;
`else
  logic grant_take;
  assign grant_take = (state_q == IDLE) && req_any;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .req1     (req1),
    .grant_en (grant_take),
    .grant_id (grant_id)
  );
`endif

  // Terminal count of the wait down-counter marks the final ACCESS edge.
  assign access_last = (state_q == ACCESS) && (wait_cnt == 4'd0);
  assign write_phase = (state_q == ACCESS) && wr_q;

  // Sequencer: latch the winner's transaction in IDLE, then walk the fixed access sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wait_cnt <= 4'd0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      mem_addr <= '0;
      owner    <= REQ_CPU;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_any) begin
            state_q  <= SETUP;
            owner    <= grant_id;
            wr_q     <= (grant_id == REQ_DMA) ? wr1 : wr0;
            mem_addr <= (grant_id == REQ_DMA) ? addr1 : addr0;
            wdata_q  <= (grant_id == REQ_DMA) ? wdata1 : wdata0;
          end
        end
        SETUP: begin
          state_q  <= ACCESS;
          wait_cnt <= WAIT_LOAD;
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            state_q <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Capture read data into the owner's result register on the final ACCESS edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (access_last && !wr_q) begin
      if (owner == REQ_DMA) begin
        rdata1 <= mem_data;
      end else begin
        rdata0 <= mem_data;
      end
    end
  end

  // Strobes decode straight from state so an async reset drops them immediately.
  assign mem_we     = write_phase;
  assign mem_busmem = write_phase;
  assign mem_membus = (state_q == ACCESS) && !wr_q;
  assign mem_data   = write_phase ? wdata_q : {DATA_WIDTH{1'bz}};
  assign busy       = (state_q != IDLE);
  assign ack0       = (state_q == DONE) && (owner == REQ_CPU);
  assign ack1       = (state_q == DONE) && (owner == REQ_DMA);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (WAIT_STATES 0 and 3), each with a RAM
// model, a queue-driven requester pair and a cycle-timeline reference model.
module tb_mem_arbiter;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         gap;
  } txn_t;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic wr, input logic [7:0] addr, input logic [7:0] wdata, input int gap);
    txn_t t;
    t.wr = wr; t.addr = addr; t.wdata = wdata; t.gap = gap;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    return mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 3));
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_inst
    localparam int WS = (g == 0) ? 0 : 3;
    localparam string P = (g == 0) ? "i0." : "i1.";

    logic [1:0] req = '0;
    logic [1:0] wr = '0;
    logic [7:0] addr [2] = '{8'h00, 8'h00};
    logic [7:0] wdata [2] = '{8'h00, 8'h00};
    logic ack0, ack1, mem_we, mem_membus, mem_busmem, busy, owner;
    logic [7:0] rdata0, rdata1, mem_addr;
    wire  [7:0] md;

    mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(WS)) u_dut (
      .clk(clk), .reset(reset),
      .req0(req[0]), .req1(req[1]), .wr0(wr[0]), .wr1(wr[1]),
      .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_data(md), .mem_we(mem_we),
      .mem_membus(mem_membus), .mem_busmem(mem_busmem), .busy(busy), .owner(owner)
    );

    // RAM: unwritten locations read as addr ^ 0x5A; a keeper value 0x69 sits on the bus when idle.
    logic [7:0] ram [256];
    bit         ram_wr [256];
    wire  [7:0] ram_q = ram_wr[mem_addr] ? ram[mem_addr] : (mem_addr ^ 8'h5A);
    assign md = mem_membus ? ram_q : (mem_we ? 8'hzz : 8'h69);
    always @(posedge clk) if (mem_we) begin
      ram[mem_addr] <= md;
      ram_wr[mem_addr] <= 1'b1;
    end

    // Reference model: one transaction timeline keyed by the grant edge.
    int edge_n = 0;
    int m_grant_edge = 0;
    bit m_active = 0, m_last = 1, m_id = 0, m_wr = 0;
    logic [7:0] m_addr = 0, m_wdata = 0;
    logic [7:0] ref_mem [256];
    bit         ref_wr [256];
    logic [7:0] exp_rd [2] = '{8'h00, 8'h00};
    bit glog [$];
    always @(posedge clk or posedge reset) begin
      int d;
      bit w;
      if (reset) begin
        m_active = 0; m_last = 1; m_id = 0;
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
      end else begin
        edge_n++;
        d = edge_n - m_grant_edge;
        if (m_active && d == 2 + WS) begin
          if (m_wr) begin
            ref_mem[m_addr] = m_wdata;
            ref_wr[m_addr] = 1'b1;
          end else begin
            exp_rd[m_id] = ref_wr[m_addr] ? ref_mem[m_addr] : (m_addr ^ 8'h5A);
          end
        end
        if ((!m_active || d >= 4 + WS) && req != 2'b00) begin
          if (req == 2'b11) w = FIXED ? 1'b0 : !m_last;
          else w = req[1];
          m_last = w; m_id = w; m_wr = wr[w]; m_addr = addr[w]; m_wdata = wdata[w];
          m_grant_edge = edge_n; m_active = 1;
          glog.push_back(w);
        end
      end
    end

    // Compare every visible output against the model once per cycle.
    int we_cyc = 0, mb_cyc = 0;
    always @(negedge clk) begin
      int d;
      bit bsy, acc, dn;
      d = edge_n - m_grant_edge;
      bsy = m_active && d <= 2 + WS;
      acc = m_active && d >= 1 && d <= 1 + WS;
      dn  = m_active && d == 2 + WS;
      we_cyc += int'(mem_we);
      mb_cyc += int'(mem_membus);
      chk({P, "busy"},   busy, bsy);
      chk({P, "ack0"},   ack0, dn && m_id == 1'b0);
      chk({P, "ack1"},   ack1, dn && m_id == 1'b1);
      chk({P, "we"},     mem_we, acc && m_wr);
      chk({P, "busmem"}, mem_busmem, acc && m_wr);
      chk({P, "membus"}, mem_membus, acc && !m_wr);
      chk({P, "owner"},  owner, m_id);
      chk({P, "rdata0"}, rdata0, exp_rd[0]);
      chk({P, "rdata1"}, rdata1, exp_rd[1]);
      chk({P, "excl"},   mem_we & mem_membus, 1'b0);
      if (bsy) chk({P, "addr"}, mem_addr, m_addr);
      if (mem_we) chk({P, "wbus"}, md, m_wdata);
      else if (mem_membus) chk({P, "rbus"}, md, ram_q);
      else chk({P, "idlebus"}, md, 8'h69);
    end

    // Requester driver: hold until ack, drop on the following edge, then start the next queued item.
    txn_t q [2][$];
    bit [1:0] active = '0;
    bit [1:0] ack_seen = '0;
    int wait_c [2] = '{0, 0};
    int raise_edge [2] = '{0, 0};
    int last_lat [2] = '{0, 0};
    int n_done = 0;
    always @(negedge clk) ack_seen = {ack1, ack0};
    always begin
      txn_t t;
      @(posedge clk);
      #1;
      for (int r = 0; r < 2; r++) begin
        if (reset) begin
          active[r] = 0; req[r] = 0; wait_c[r] = 0;
          q[r].delete();
        end else begin
          if (active[r] && ack_seen[r]) begin
            active[r] = 0; req[r] = 0; wait_c[r] = 0;
            last_lat[r] = edge_n - raise_edge[r];
            n_done++;
          end
          if (!active[r] && q[r].size() > 0) begin
            if (wait_c[r] >= q[r][0].gap) begin
              t = q[r].pop_front();
              req[r] = 1; wr[r] = t.wr; addr[r] = t.addr; wdata[r] = t.wdata;
              active[r] = 1; raise_edge[r] = edge_n;
            end else begin
              wait_c[r]++;
            end
          end
        end
      end
    end
  end

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (n < 5000 && !(gen_inst[0].q[0].size() == 0 && gen_inst[0].q[1].size() == 0 &&
                         gen_inst[1].q[0].size() == 0 && gen_inst[1].q[1].size() == 0 &&
                         gen_inst[0].active == 2'b00 && gen_inst[1].active == 2'b00 &&
                         !gen_inst[0].busy && !gen_inst[1].busy)) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, n < 5000, 1'b1);
  endtask

  initial begin
    int base, we0, mb0, d0, d1, n;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", gen_inst[0].busy, 1'b0);
    chk("rst_addr", gen_inst[0].mem_addr, 8'h00);
    chk("rst_owner", gen_inst[1].owner, 1'b0);
    chk("rst_rdata", gen_inst[0].rdata0, 8'h00);
    #1 reset = 1'b0;

    // Contention from the reset pointer; requester 0 re-requests right after its ack.
    base = gen_inst[0].glog.size();
    gen_inst[0].q[0].push_back(mk(1'b0, 8'h20, 8'h00, 0));
    gen_inst[0].q[0].push_back(mk(1'b0, 8'h21, 8'h00, 0));
    gen_inst[0].q[1].push_back(mk(1'b1, 8'h21, 8'h3C, 0));
    wait_idle("cont");
    chk("cont_n", gen_inst[0].glog.size() - base, 3);
    if (gen_inst[0].glog.size() - base == 3) begin
      chk("cont_g0", gen_inst[0].glog[base], 1'b0);
      chk("cont_g1", gen_inst[0].glog[base+1], FIXED ? 1'b0 : 1'b1);
      chk("cont_g2", gen_inst[0].glog[base+2], FIXED ? 1'b1 : 1'b0);
    end
    chk("cont_rd", gen_inst[0].rdata0, FIXED ? 8'h7B : 8'h3C);

    // Write then read back, zero wait states.
    we0 = gen_inst[0].we_cyc;
    gen_inst[0].q[0].push_back(mk(1'b1, 8'h10, 8'hA5, 0));
    gen_inst[0].q[0].push_back(mk(1'b0, 8'h10, 8'h00, 2));
    wait_idle("wrrd");
    chk("wrrd_data", gen_inst[0].rdata0, 8'hA5);
    chk("wrrd_we_cyc", gen_inst[0].we_cyc - we0, 1);
    chk("wrrd_lat", gen_inst[0].last_lat[0], 4);

    // Three wait states on requester 1.
    mb0 = gen_inst[1].mb_cyc;
    gen_inst[1].q[1].push_back(mk(1'b0, 8'h55, 8'h00, 0));
    wait_idle("ws3");
    chk("ws3_mb_cyc", gen_inst[1].mb_cyc - mb0, 4);
    chk("ws3_lat", gen_inst[1].last_lat[1], 7);
    chk("ws3_data", gen_inst[1].rdata1, 8'h0F);

    // Reset during a write's ACCESS cycle.
    gen_inst[0].q[0].push_back(mk(1'b1, 8'h40, 8'hEE, 0));
    n = 0;
    while (n < 100 && !gen_inst[0].mem_we) begin
      @(negedge clk);
      n++;
    end
    chk("rst_we_seen", gen_inst[0].mem_we, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("rst_we", gen_inst[0].mem_we, 1'b0);
    chk("rst_membus", gen_inst[0].mem_membus, 1'b0);
    chk("rst_busmem", gen_inst[0].mem_busmem, 1'b0);
    chk("rst_bus", gen_inst[0].md, 8'h69);
    chk("rst_busy2", gen_inst[0].busy, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_noack", gen_inst[0].ack0, 1'b0);
    #1 reset = 1'b0;
    gen_inst[0].q[0].push_back(mk(1'b0, 8'h40, 8'h00, 0));
    wait_idle("rst_rd");
    chk("rst_rd_data", gen_inst[0].rdata0, 8'h1A);

    // Random mix: 100 transactions per instance, 200 total.
    d0 = gen_inst[0].n_done;
    d1 = gen_inst[1].n_done;
    for (int i = 0; i < 50; i++) begin
      for (int r = 0; r < 2; r++) begin
        gen_inst[0].q[r].push_back(rnd_txn());
        gen_inst[1].q[r].push_back(rnd_txn());
      end
    end
    wait_idle("rand");
    chk("rand_done0", gen_inst[0].n_done - d0, 100);
    chk("rand_done1", gen_inst[1].n_done - d1, 100);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
